// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the Reed-Solomon syndrome datapath.
//   PRIM_POLY     : GF(2^8) primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D)
//   DEF_M/NSYM/FCR: default code parameters for RS(255,k)
//   state_e       : syndrome FSM states
//   gf_xtime      : multiply by alpha (x) with reduction
//   gf_alpha_pow  : elaboration-time alpha^e, exponent reduced mod 255
package rs_pkg;

  localparam logic [8:0] PRIM_POLY = 9'h11D;
  localparam int         GF_W      = 8;
  localparam int         GF_ORDER  = 255;
  localparam int         DEF_M     = 255;
  localparam int         DEF_NSYM  = 16;
  localparam int         DEF_FCR   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
    return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? PRIM_POLY[GF_W-1:0] : '0);
  endfunction

  function automatic logic [GF_W-1:0] gf_alpha_pow(input int e);
    int              r;
    logic [GF_W-1:0] v;
    r = e % GF_ORDER;
    if (r < 0) r = r + GF_ORDER;
    v = 8'h01;
    for (int i = 0; i < r; i++) v = gf_xtime(v);
    return v;
  endfunction

endpackage

// File: rtl/rs_gf_mul.sv
// rs_gf_mul: combinational GF(2^8) multiplier, shift-and-XOR form.
//   a : variable operand (running syndrome)
//   b : operand (tied to a constant root at instantiation)
//   p : a*b reduced by PRIM_POLY
// With b constant, synthesis folds this down to a small XOR network.
module rs_gf_mul
  import rs_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  output logic [GF_W-1:0] p
);

  always_comb begin
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    p = acc;
  end

endmodule

// File: rtl/rs_syndrome.sv
// rs_syndrome: streaming RS(255,k) syndrome calculator.
// Horner accumulation S_j <= S_j*alpha^(FCR+j) ^ r_i over symbols received
// highest degree first; results are held behind a valid/ready handshake.
//   clk, rst_n        : clock, async active-low reset
//   in_valid/in_ready : symbol handshake (in_ready depends on state only)
//   in_sym, in_last   : received symbol, end-of-codeword marker
//   out_valid/ready   : syndrome handshake
//   out_syn           : S_j at bits [j*SIZE +: SIZE]
//   out_len_err       : accepted symbol count != M
//   out_nz            : some syndrome nonzero
// Build option: RS_SYNDROME_NZ_EN enables the out_nz reduction; when it is
// undefined out_nz is constant 0 and the port list is unchanged.
module rs_syndrome
  import rs_pkg::*;
#(
  parameter int M    = DEF_M,
  parameter int SIZE = $clog2(M),
  parameter int NSYM = DEF_NSYM,
  parameter int FCR  = DEF_FCR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      in_sym,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSYM*SIZE-1:0] out_syn,
  output logic                 out_len_err,
  output logic                 out_nz
);

  state_e                      state_q, state_d;
  logic [NSYM-1:0][SIZE-1:0]   syn_q, syn_d, prod;
  logic [8:0]                  cnt_q, cnt_d;
  logic                        len_err_q, len_err_d;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic                        in_fire, to_hold;

  assign in_fire = in_valid & in_ready_q;
  // A transfer carrying in_last is the only way into HOLD.
  assign to_hold = in_fire & in_last;

  // One constant-root multiplier per syndrome lane.
  for (genvar j = 0; j < NSYM; j++) begin : g_lane
    localparam logic [GF_W-1:0] ROOT = gf_alpha_pow(FCR + j);
    rs_gf_mul u_mul (
      .a (syn_q[j]),
      .b (ROOT),
      .p (prod[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    syn_d     = syn_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          for (int j = 0; j < NSYM; j++) syn_d[j] = in_sym;
          cnt_d   = 9'd1;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          for (int j = 0; j < NSYM; j++) syn_d[j] = prod[j] ^ in_sym;
          cnt_d = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (to_hold) len_err_d = (cnt_d != 9'(M));
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      syn_q       <= '0;
      cnt_q       <= '0;
      len_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      syn_q       <= syn_d;
      cnt_q       <= cnt_d;
      len_err_q   <= len_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef RS_SYNDROME_NZ_EN
  logic nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (to_hold) nz_d = |syn_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nz_q <= 1'b0;
    else        nz_q <= nz_d;
  end

  assign out_nz = nz_q;
`else
  assign out_nz = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_syn     = syn_q;
  assign out_len_err = len_err_q;

endmodule
